// File: rtl/bus_arb_mux.sv
// bus_arb_mux: N-master bus arbiter with master-side multiplexer.
//
// Grants the shared bus to one of NUM_M masters (fixed priority or round-robin),
// optionally forces a hand-over after MAX_HOLD consecutive ownership cycles, and
// routes the owner's address/strobe/rw/write data to the slave decoder.
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to enable the slave-ready timeout
// (forced m_rdy_no plus a one-cycle bus_err_o after TIMEOUT_CYC stalled cycles).
//
// Ports:
//   clk_i        clock
//   reset_ni     synchronous active-low reset
//   m_req_ni     per-master request (active-low)
//   m_addr_i     flattened master addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_as_ni      per-master address strobe (active-low)
//   m_rw_i       per-master read/write (1 = read)
//   m_wr_data_i  flattened master write data
//   m_grnt_no    one-hot grant (active-low)
//   s_addr_o     selected address
//   s_as_no      selected strobe (active-low)
//   s_rw_o       selected read/write
//   s_wr_data_o  selected write data
//   s_rdy_ni     ready from slave decoder (active-low)
//   m_rdy_no     ready returned to masters (active-low)
//   owner_o      index of current owner
//   bus_err_o    timeout error pulse
module bus_arb_mux #(
    parameter int unsigned NUM_M       = 4,
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ARB_MODE    = 0,
    parameter int unsigned MAX_HOLD    = 0,
    parameter int unsigned TIMEOUT_CYC = 64,
    localparam int unsigned OWN_W      = $clog2(NUM_M)
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [NUM_M-1:0]        m_req_ni,
    input  logic [NUM_M*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_M-1:0]        m_as_ni,
    input  logic [NUM_M-1:0]        m_rw_i,
    input  logic [NUM_M*DATA_W-1:0] m_wr_data_i,
    output logic [NUM_M-1:0]        m_grnt_no,
    output logic [ADDR_W-1:0]       s_addr_o,
    output logic                    s_as_no,
    output logic                    s_rw_o,
    output logic [DATA_W-1:0]       s_wr_data_o,
    input  logic                    s_rdy_ni,
    output logic                    m_rdy_no,
    output logic [OWN_W-1:0]        owner_o,
    output logic                    bus_err_o
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    if (NUM_M < 2 || NUM_M > 16) begin : g_bad_num_m
        $error("bus_arb_mux: NUM_M out of range");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("bus_arb_mux: TIMEOUT_CYC must be at least 2");
    end

    logic [OWN_W-1:0]  owner_q, owner_d;
    logic [NUM_M-1:0]  grnt_q, grnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [NUM_M-1:0]  cand;
    logic              rel, force_ho, owner_chg;
    logic [OWN_W-1:0]  win;
    logic              win_vld;
    int unsigned       idx;

    // Output mux follows the owner register.
    assign s_addr_o    = m_addr_i[owner_q*ADDR_W +: ADDR_W];
    assign s_wr_data_o = m_wr_data_i[owner_q*DATA_W +: DATA_W];
    assign s_as_no     = m_as_ni[owner_q];
    assign s_rw_o      = m_rw_i[owner_q];
    assign m_grnt_no   = grnt_q;
    assign owner_o     = owner_q;

    always_comb begin
        // Owner is never a candidate: on release it is not requesting anyway,
        // on forced hand-over it must be excluded.
        cand           = ~m_req_ni;
        cand[owner_q]  = 1'b0;
        rel            = m_req_ni[owner_q];
        force_ho       = 1'b0;
        if (MAX_HOLD != 0) begin
            force_ho = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) && (|cand) && m_as_ni[owner_q];
        end

        win     = owner_q;
        win_vld = 1'b0;
        idx     = 0;
        if (ARB_MODE == 0) begin
            // Descending scan, last hit wins -> lowest index has priority.
            for (int i = NUM_M - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    win     = OWN_W'(i);
                    win_vld = 1'b1;
                end
            end
        end else begin
            // Descending distance scan -> nearest successor of owner wins.
            for (int k = NUM_M - 1; k >= 1; k--) begin
                idx = (32'(owner_q) + 32'(k)) % NUM_M;
                if (cand[idx]) begin
                    win     = OWN_W'(idx);
                    win_vld = 1'b1;
                end
            end
        end

        owner_d = owner_q;
        if ((rel || force_ho) && win_vld) begin
            owner_d = win;
        end
        owner_chg = (owner_d != owner_q);

        grnt_d          = '1;
        grnt_d[owner_d] = 1'b0;

        if (MAX_HOLD == 0 || owner_chg || rel) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_W'(MAX_HOLD - 1)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            owner_q    <= '0;
            grnt_q     <= {{(NUM_M-1){1'b1}}, 1'b0};
            hold_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            grnt_q     <= grnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic            stall, to_hit;

    always_comb begin
        stall    = !s_as_no && s_rdy_ni && !owner_chg;
        to_hit   = stall && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
        // Counter restarts after the forced completion.
        to_cnt_d = (stall && !to_hit) ? to_cnt_q + 1'b1 : '0;
        err_d    = to_hit;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign m_rdy_no  = s_rdy_ni & ~err_q;
    assign bus_err_o = err_q;
`else
    assign m_rdy_no  = s_rdy_ni;
    assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arb_mux.sv
module tb_bus_arb_mux;

    localparam int NM = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int NI = 3;  // 0: fixed, 1: round-robin, 2: fixed + MAX_HOLD 8

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NM-1:0]    req_n = '1;
    logic [NM-1:0]    as_n = '1;
    logic [NM-1:0]    rw = '0;
    logic [NM*AW-1:0] addr = '0;
    logic [NM*DW-1:0] wdata = '0;
    logic             s_rdy_n = 1'b0;

    logic [NM-1:0] grnt_n  [NI];
    logic [AW-1:0] s_addr  [NI];
    logic          s_as_n  [NI];
    logic          s_rw    [NI];
    logic [DW-1:0] s_wd    [NI];
    logic          m_rdy_n [NI];
    logic [1:0]    own     [NI];
    logic          berr    [NI];

    bus_arb_mux #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .MAX_HOLD(0),
                  .TIMEOUT_CYC(16)) u_fix (
        .clk_i(clk), .reset_ni(rst_n), .m_req_ni(req_n), .m_addr_i(addr), .m_as_ni(as_n),
        .m_rw_i(rw), .m_wr_data_i(wdata), .m_grnt_no(grnt_n[0]), .s_addr_o(s_addr[0]),
        .s_as_no(s_as_n[0]), .s_rw_o(s_rw[0]), .s_wr_data_o(s_wd[0]), .s_rdy_ni(s_rdy_n),
        .m_rdy_no(m_rdy_n[0]), .owner_o(own[0]), .bus_err_o(berr[0]));

    bus_arb_mux #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .MAX_HOLD(0),
                  .TIMEOUT_CYC(16)) u_rr (
        .clk_i(clk), .reset_ni(rst_n), .m_req_ni(req_n), .m_addr_i(addr), .m_as_ni(as_n),
        .m_rw_i(rw), .m_wr_data_i(wdata), .m_grnt_no(grnt_n[1]), .s_addr_o(s_addr[1]),
        .s_as_no(s_as_n[1]), .s_rw_o(s_rw[1]), .s_wr_data_o(s_wd[1]), .s_rdy_ni(s_rdy_n),
        .m_rdy_no(m_rdy_n[1]), .owner_o(own[1]), .bus_err_o(berr[1]));

    bus_arb_mux #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .MAX_HOLD(8),
                  .TIMEOUT_CYC(16)) u_sg (
        .clk_i(clk), .reset_ni(rst_n), .m_req_ni(req_n), .m_addr_i(addr), .m_as_ni(as_n),
        .m_rw_i(rw), .m_wr_data_i(wdata), .m_grnt_no(grnt_n[2]), .s_addr_o(s_addr[2]),
        .s_as_no(s_as_n[2]), .s_rw_o(s_rw[2]), .s_wr_data_o(s_wd[2]), .s_rdy_ni(s_rdy_n),
        .m_rdy_no(m_rdy_n[2]), .owner_o(own[2]), .bus_err_o(berr[2]));

    int n_cmp = 0;
    int n_bad = 0;
    int m_own [NI];
    int m_hold [NI];
    int sb_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbiter: one cycle of next-owner / hold-count evolution.
    task automatic model_step(input int mode, input int mh, input int own_in, input int hold_in,
                              output int own_out, output int hold_out);
        logic rel, others, frc;
        rel    = req_n[own_in];
        others = 1'b0;
        for (int j = 0; j < NM; j++) begin
            if (j != own_in && !req_n[j]) others = 1'b1;
        end
        frc = (mh != 0) && (hold_in == mh - 1) && others && as_n[own_in];
        own_out = own_in;
        if ((rel || frc) && others) begin
            if (mode == 0) begin
                for (int j = NM - 1; j >= 0; j--) begin
                    if (j != own_in && !req_n[j]) own_out = j;
                end
            end else begin
                for (int k = NM - 1; k >= 1; k--) begin
                    if (!req_n[(own_in + k) % NM]) own_out = (own_in + k) % NM;
                end
            end
        end
        if (mh == 0 || own_out != own_in || rel) hold_out = 0;
        else if (hold_in < mh - 1) hold_out = hold_in + 1;
        else hold_out = hold_in;
    endtask

    // Push expected owners, advance one clock, then pop and compare every instance.
    task automatic step();
        int no, nh, e;
        logic [NM-1:0] g;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                no = 0;
                nh = 0;
            end else begin
                model_step((i == 1) ? 1 : 0, (i == 2) ? 8 : 0, m_own[i], m_hold[i], no, nh);
            end
            m_own[i]  = no;
            m_hold[i] = nh;
            sb_q.push_back(no);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            e    = sb_q.pop_front();
            g    = '1;
            g[e] = 1'b0;
            check_eq($sformatf("owner[%0d]", i), 64'(own[i]), 64'(e));
            check_eq($sformatf("grant[%0d]", i), 64'(grnt_n[i]), 64'(g));
            check_eq($sformatf("s_addr[%0d]", i), 64'(s_addr[i]), 64'(addr[e*AW +: AW]));
            check_eq($sformatf("s_wdata[%0d]", i), 64'(s_wd[i]), 64'(wdata[e*DW +: DW]));
            check_eq($sformatf("s_as[%0d]", i), 64'(s_as_n[i]), 64'(as_n[e]));
            check_eq($sformatf("s_rw[%0d]", i), 64'(s_rw[i]), 64'(rw[e]));
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req_n   = '1;
        as_n    = '1;
        s_rdy_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic exp_err;
        int   cur;
        for (int i = 0; i < NM; i++) begin
            addr[i*AW +: AW]  = AW'(32'h100 + i);
            wdata[i*DW +: DW] = 32'hA0A0_0000 + i;
            rw[i]             = i[0];
        end

        // Reset
        do_reset();
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("rst_owner[%0d]", i), 64'(own[i]), 64'd0);
            check_eq($sformatf("rst_grant[%0d]", i), 64'(grnt_n[i]), 64'h0E);
            check_eq($sformatf("rst_berr[%0d]", i), 64'(berr[i]), 64'd0);
        end

        // Fixed priority: master 0 holds, 2 and 3 join, master 0 releases.
        req_n = 4'b1110;
        step();
        step();
        req_n = 4'b0010;
        step();
        check_eq("fix_hold_owner", 64'(own[0]), 64'd0);
        req_n = 4'b0011;
        step();
        check_eq("fix_owner", 64'(own[0]), 64'd2);
        check_eq("fix_grant", 64'(grnt_n[0]), 64'h0B);
        check_eq("fix_s_addr", 64'(s_addr[0]), 64'h102);

        // Round-robin: everyone requests, owner strobes then releases one cycle.
        do_reset();
        req_n = '0;
        step();
        check_eq("rr_start", 64'(own[1]), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cur   = k % NM;
            as_n  = ~(4'b0001 << cur);
            step();
            as_n  = '1;
            req_n = 4'b0001 << cur;
            step();
            check_eq($sformatf("rr_seq%0d", k), 64'(own[1]), 64'((k + 1) % NM));
            req_n = '0;
        end

        // Starvation guard: master 1 holds unstrobed, master 3 waits.
        do_reset();
        req_n = 4'b0101;
        step();
        check_eq("sg_grant", 64'(own[2]), 64'd1);
        for (int c = 1; c <= 8; c++) begin
            step();
            check_eq($sformatf("sg_hold%0d", c), 64'(own[2]), (c == 8) ? 64'd3 : 64'd1);
        end
        check_eq("sg_nofix", 64'(own[0]), 64'd1);

        // Same, but master 1 keeps its strobe asserted.
        do_reset();
        req_n = 4'b0101;
        as_n  = 4'b1101;
        step();
        for (int c = 1; c <= 12; c++) begin
            step();
            check_eq($sformatf("sg_strobe%0d", c), 64'(own[2]), 64'd1);
        end
        as_n = '1;
        step();
        check_eq("sg_release", 64'(own[2]), 64'd3);

        // Ready pass-through, then slave-ready timeout.
        do_reset();
        req_n   = 4'b1110;
        as_n    = 4'b1110;
        s_rdy_n = 1'b0;
        step();
        check_eq("rdy_pass0", 64'(m_rdy_n[0]), 64'd0);
        as_n = '1;
        step();
        as_n    = 4'b1110;
        s_rdy_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
`ifdef BUS_ARB_TIMEOUT_EN
            exp_err = (k == 16);
`else
            exp_err = 1'b0;
`endif
            check_eq($sformatf("to_berr%0d", k), 64'(berr[0]), 64'(exp_err));
            check_eq($sformatf("to_mrdy%0d", k), 64'(m_rdy_n[0]), 64'(!exp_err));
        end

        // Reset in the middle of a strobed access.
        req_n = 4'b1101;
        step();
        rst_n = 1'b0;
        step();
        check_eq("midrst_owner", 64'(own[0]), 64'd0);
        check_eq("midrst_berr", 64'(berr[0]), 64'd0);
        rst_n   = 1'b1;
        s_rdy_n = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 300; c++) begin
            req_n = 4'($urandom_range(0, 15));
            as_n  = 4'($urandom_range(0, 15));
            rw    = 4'($urandom_range(0, 15));
            for (int i = 0; i < NM; i++) begin
                addr[i*AW +: AW]  = AW'($urandom);
                wdata[i*DW +: DW] = $urandom;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
